// File: rtl/nibbler_io_bridge.sv
// nibbler_io_bridge: IN/OUT port responder with synchronized inputs, latched outputs and a port-3 stream FIFO
module nibbler_io_bridge #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   io_addr,
    input  logic         io_wr,
    input  logic [N-1:0] io_wdata,
    input  logic         io_rd,
    output logic [N-1:0] io_rdata,
    input  logic [N-1:0] In0,
    input  logic [N-1:0] In1,
    input  logic [N-1:0] In2,
    output logic [N-1:0] Out0,
    output logic [N-1:0] Out1,
    output logic [N-1:0] Out2,
    output logic [N-1:0] tx_data,
    output logic         tx_valid,
    input  logic         tx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [2:0][N-1:0]       s1_q, s1_d, s2_q, s2_d, out_q, out_d;
    logic [DEPTH-1:0][N-1:0] mem_q, mem_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    full, empty, pop, push_req, push, drop;
    logic [N-1:0]            status;
    assign full     = count_q == CW'(DEPTH);
    assign empty    = count_q == '0;
    assign tx_valid = !empty;
    assign tx_data  = mem_q[rd_ptr_q];
    assign pop      = tx_valid && tx_ready;
    assign push_req = io_wr && io_addr == 2'd3;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign status   = N'({ovf_q, full, empty, 1'b0});
    assign io_rdata = io_addr == 2'd3 ? status : s2_q[io_addr];
    assign Out0     = out_q[0];
    assign Out1     = out_q[1];
    assign Out2     = out_q[2];
    always_comb begin
        s1_d     = {In2, In1, In0};
        s2_d     = s1_q;
        out_d    = out_q;
        mem_d    = mem_q;
        if (io_wr && io_addr != 2'd3) out_d[io_addr] = io_wdata;
        if (push) mem_d[wr_ptr_q] = io_wdata;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = drop ? 1'b1 : (io_rd && io_addr == 2'd3) ? 1'b0 : ovf_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            out_q    <= '0;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            out_q    <= out_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_nibbler_io_bridge.sv
// tb_nibbler_io_bridge: directed bench with a queue scoreboard for the port-3 stream
module tb_nibbler_io_bridge;
    logic       clk, reset;
    logic [1:0] io_addr;
    logic       io_wr, io_rd, tx_valid, tx_ready;
    logic [3:0] io_wdata, io_rdata, In0, In1, In2, Out0, Out1, Out2, tx_data;
    logic [3:0] sbq[$];
    int         n_cmp = 0;
    int         n_err = 0;

    nibbler_io_bridge #(.N(4), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .io_addr(io_addr), .io_wr(io_wr), .io_wdata(io_wdata),
        .io_rd(io_rd), .io_rdata(io_rdata), .In0(In0), .In1(In1), .In2(In2),
        .Out0(Out0), .Out1(Out1), .Out2(Out2), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd(logic [1:0] a, logic [3:0] e, string tag);
        io_addr = a;
        #1;
        chk(tag, 8'(io_rdata), 8'(e));
    endtask

    // Scoreboard step: model the pop/push that happens at the coming edge, then advance.
    task automatic cyc();
        logic [3:0] e;
        bit         pop;
        pop = tx_valid && tx_ready;
        chk("tx_valid", 8'(tx_valid), 8'(sbq.size() != 0));
        if (pop && sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("tx_data", 8'(tx_data), 8'(e));
        end
        if (io_wr && io_addr == 2'd3 && sbq.size() < 4) sbq.push_back(io_wdata);
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [3:0] v);
        io_addr  = 2'd3;
        io_wdata = v;
        io_wr    = 1'b1;
        cyc();
        io_wr    = 1'b0;
    endtask

    initial begin
        reset = 1'b0; io_addr = 2'd0; io_wr = 1'b0; io_rd = 1'b0; io_wdata = 4'd0;
        tx_ready = 1'b0; In0 = 4'd6; In1 = 4'd4; In2 = 4'd1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out0", 8'(Out0), 8'h0);
        chk("rst_out1", 8'(Out1), 8'h0);
        chk("rst_out2", 8'(Out2), 8'h0);
        chk("rst_tx_valid", 8'(tx_valid), 8'h0);
        chk("rst_tx_data", 8'(tx_data), 8'h0);
        rd(2'd3, 4'b0010, "rst_status");
        rd(2'd0, 4'd0, "rst_in0");
        io_addr = 2'd0;
        reset = 1'b1;
        cyc();
        cyc();
        rd(2'd0, 4'd6, "sync_in0");
        rd(2'd1, 4'd4, "sync_in1");
        rd(2'd2, 4'd1, "sync_in2");
        io_addr = 2'd1; io_wdata = 4'd9; io_wr = 1'b1;
        cyc();
        io_wr = 1'b0;
        chk("out1_9", 8'(Out1), 8'h9);
        chk("out0_keep", 8'(Out0), 8'h0);
        chk("out2_keep", 8'(Out2), 8'h0);
        io_addr = 2'd1; io_wdata = 4'd3; io_wr = 1'b1;
        cyc();
        io_addr = 2'd2;
        cyc();
        io_wr = 1'b0;
        chk("out1_3", 8'(Out1), 8'h3);
        chk("out2_3", 8'(Out2), 8'h3);
        chk("out0_still", 8'(Out0), 8'h0);
        for (int v = 1; v <= 4; v++) push(4'(v));
        rd(2'd3, 4'b0100, "st_full");
        chk("head_1", 8'(tx_data), 8'h1);
        push(4'd7);
        rd(2'd3, 4'b1100, "st_ovf");
        io_rd = 1'b1;
        rd(2'd3, 4'b1100, "st_ovf_rd");
        cyc();
        io_rd = 1'b0;
        rd(2'd3, 4'b0100, "st_ovf_clr");
        io_rd = 1'b1;
        push(4'd7);
        io_rd = 1'b0;
        rd(2'd3, 4'b1100, "st_set_wins");
        io_rd = 1'b1;
        cyc();
        io_rd = 1'b0;
        rd(2'd3, 4'b0100, "st_clr2");
        tx_ready = 1'b1;
        repeat (4) cyc();
        chk("drained_valid", 8'(tx_valid), 8'h0);
        rd(2'd3, 4'b0010, "st_empty");
        tx_ready = 1'b0;
        for (int v = 10; v <= 13; v++) push(4'(v));
        tx_ready = 1'b1;
        push(4'd5);
        tx_ready = 1'b0;
        rd(2'd3, 4'b0100, "st_pushpop");
        tx_ready = 1'b1;
        repeat (4) cyc();
        tx_ready = 1'b0;
        chk("pp_drained", 8'(tx_valid), 8'h0);
        io_addr = 2'd0; io_wdata = 4'd5; io_wr = 1'b1;
        cyc();
        io_wr = 1'b0;
        for (int v = 1; v <= 3; v++) push(4'(v));
        chk("mid_out0", 8'(Out0), 8'h5);
        chk("mid_valid", 8'(tx_valid), 8'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 8'(tx_valid), 8'h0);
        chk("arst_out0", 8'(Out0), 8'h0);
        chk("arst_tx_data", 8'(tx_data), 8'h0);
        rd(2'd3, 4'b0010, "arst_status");
        rd(2'd0, 4'd0, "arst_in0");
        sbq.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        push(4'd8);
        chk("post_valid", 8'(tx_valid), 8'h1);
        chk("post_data", 8'(tx_data), 8'h8);
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        chk("post_drain", 8'(tx_valid), 8'h0);
        chk("sb_empty", 8'(sbq.size()), 8'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
